// File: rtl/l2_writeback_buffer_if.sv
// ---------------------------------------------------------------------------
// l2_writeback_buffer_if
//   Bundles the L2-side request/response signals and the physical-memory
//   side signals of the L2 write-back buffer into one interface.
//
//   L2 side      : l2_read, l2_write, l2_address[15:0], l2_wdata[127:0]
//                  (requests, held by L2 until l2_resp)
//                  l2_resp, l2_rdata[127:0] (completion pulse + read data)
//   Memory side  : pmem_read, pmem_write, pmem_address[15:0],
//                  pmem_wdata[127:0] (buffer-issued memory operation)
//                  pmem_rdata[127:0], pmem_resp (memory completion)
//   Status       : wb_empty (no buffered lines and no drain in flight)
//
//   Modports
//     slave  : the write-back buffer itself
//     master : the environment around it (L2 controller + memory)
// ---------------------------------------------------------------------------
interface l2_writeback_buffer_if;
   logic         l2_read;
   logic         l2_write;
   logic [15:0]  l2_address;
   logic [127:0] l2_wdata;
   logic         l2_resp;
   logic [127:0] l2_rdata;

   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   logic         wb_empty;

   modport slave (
      input  l2_read, l2_write, l2_address, l2_wdata, pmem_rdata, pmem_resp,
      output l2_resp, l2_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
             wb_empty
   );

   modport master (
      output l2_read, l2_write, l2_address, l2_wdata, pmem_rdata, pmem_resp,
      input  l2_resp, l2_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
             wb_empty
   );
endinterface

// File: rtl/l2_writeback_buffer.sv
// ---------------------------------------------------------------------------
// l2_writeback_buffer
//   Victim / write-back buffer sitting between the L2 cache and physical
//   memory. Dirty lines evicted by L2 are absorbed in one cycle into a small
//   circular FIFO, drained to memory whenever no L2 read is waiting, and
//   forwarded back to L2 when L2 reads a line that is still held here.
//
//   Parameters
//     DEPTH  : number of line entries (>= 1)
//
//   Ports
//     clk    : clock, all state changes on the rising edge
//     reset  : asynchronous, active-high reset
//     wbBus  : l2_writeback_buffer_if.slave
//              L2 requests in (l2_read/l2_write/l2_address/l2_wdata),
//              l2_resp/l2_rdata out, pmem_read/pmem_write/pmem_address/
//              pmem_wdata out, pmem_rdata/pmem_resp in, wb_empty out
// ---------------------------------------------------------------------------
module l2_writeback_buffer #(
   parameter int DEPTH = 2
) (
   input logic                  clk,
   input logic                  reset,
   l2_writeback_buffer_if.slave wbBus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } pmemState_t;

   pmemState_t    r_state;
   pmemState_t    w_nextState;

   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [11:0]   r_lineAddr [DEPTH];
   logic [127:0]  r_lineData [DEPTH];

   logic          r_l2Resp;
   logic [127:0]  r_l2Rdata;
   logic          r_pmemRead;
   logic          r_pmemWrite;
   logic [15:0]   r_pmemAddr;

   logic [11:0]   w_reqLine;
   logic [PW-1:0] w_scanIdx;
   logic [PW-1:0] w_readIdx;
   logic [PW-1:0] w_writeIdx;
   logic          w_readHit;
   logic          w_writeHit;
   logic          w_reqWrite;
   logic          w_reqRead;
   logic          w_full;
   logic          w_enqueue;
   logic          w_overwrite;
   logic          w_readMiss;
   logic          w_readHitResp;
   logic          w_readDone;
   logic          w_retire;
   logic          w_respNext;

   // Advance a FIFO pointer by offset, wrapping from DEPTH-1 back to 0.
   // Works for any DEPTH, not only powers of two.
   function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= DEPTH) begin
         sum = sum - DEPTH;
      end
      return PW'(sum);
   endfunction

   // The low nibble of the L2 address selects a word inside the line and is
   // irrelevant here; shifting keeps just the line number.
   assign w_reqLine = 12'(wbBus.l2_address >> 4);

   // Scan the live entries from oldest to youngest so the last hit seen is the
   // youngest copy of the line. Reads may hit the head even while it is being
   // written to memory (its data is still intact), but writes must not touch
   // the in-flight head, so the write hit skips it and a same-line write then
   // falls through to a fresh allocation.
   always_comb begin
      w_readHit  = 1'b0;
      w_readIdx  = '0;
      w_writeHit = 1'b0;
      w_writeIdx = '0;
      w_scanIdx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_scanIdx = ptrAdd(r_head, k);
         if ((k < int'(r_count)) && (r_lineAddr[w_scanIdx] == w_reqLine)) begin
            w_readHit = 1'b1;
            w_readIdx = w_scanIdx;
            if (!((k == 0) && (r_state == DRAIN))) begin
               w_writeHit = 1'b1;
               w_writeIdx = w_scanIdx;
            end
         end
      end
   end

   // Decode what the current L2 request wants this cycle. A request is only
   // looked at while no response is being presented, so a request that is
   // still high during its own response cycle is not taken twice. Writes win
   // over reads if both are raised. Everything is re-evaluated each cycle,
   // which is what lets a stalled write or a read waiting behind a drain
   // retry naturally once the buffer state changes.
   always_comb begin
      w_reqWrite    = !r_l2Resp && wbBus.l2_write;
      w_reqRead     = !r_l2Resp && wbBus.l2_read && !wbBus.l2_write;
      w_full        = (r_count == CW'(DEPTH));
      w_overwrite   = w_reqWrite && w_writeHit;
      w_enqueue     = w_reqWrite && !w_writeHit && !w_full;
      w_readHitResp = w_reqRead && w_readHit && (r_state != READ);
      w_readMiss    = w_reqRead && !w_readHit;
      w_readDone    = (r_state == READ) && wbBus.pmem_resp;
      w_retire      = (r_state == DRAIN) && wbBus.pmem_resp;
      w_respNext    = w_enqueue || w_overwrite || w_readHitResp || w_readDone;
   end

   // Memory-side FSM next state. A waiting read miss beats draining so L2
   // is not held up by write-backs. Leaving READ or DRAIN always goes back
   // through IDLE, so no new memory operation begins in the cycle a
   // completion is seen.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_readMiss) begin
               w_nextState = READ;
            end else if (r_count != '0) begin
               w_nextState = DRAIN;
            end
         end
         READ: begin
            if (wbBus.pmem_resp) begin
               w_nextState = IDLE;
            end
         end
         DRAIN: begin
            if (wbBus.pmem_resp) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // FSM state register plus the registered memory request outputs. The
   // memory address is captured when an operation starts and then stays put
   // until that operation completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_pmemRead  <= 1'b0;
         r_pmemWrite <= 1'b0;
         r_pmemAddr  <= '0;
      end else begin
         r_state     <= w_nextState;
         r_pmemRead  <= (w_nextState == READ);
         r_pmemWrite <= (w_nextState == DRAIN);
         if ((r_state == IDLE) && (w_nextState == READ)) begin
            r_pmemAddr <= {w_reqLine, 4'b0000};
         end else if ((r_state == IDLE) && (w_nextState == DRAIN)) begin
            r_pmemAddr <= {r_lineAddr[r_head], 4'b0000};
         end
      end
   end

   // Entry storage and FIFO bookkeeping. An enqueue and a drain retirement
   // in the same edge leave the occupancy unchanged. An overwrite lands on
   // an entry that is not in flight, so memory never sees data change under
   // an active write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_lineAddr[i] <= '0;
            r_lineData[i] <= '0;
         end
      end else begin
         if (w_overwrite) begin
            r_lineData[w_writeIdx] <= wbBus.l2_wdata;
         end
         if (w_enqueue) begin
            r_lineAddr[r_tail] <= w_reqLine;
            r_lineData[r_tail] <= wbBus.l2_wdata;
            r_tail             <= ptrAdd(r_tail, 1);
         end
         if (w_retire) begin
            r_head <= ptrAdd(r_head, 1);
         end
         case ({w_enqueue, w_retire})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // L2 response pulse and read data. Data comes either from a buffered
   // line (hit) or from memory (miss completion), and is held afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_l2Resp  <= 1'b0;
         r_l2Rdata <= '0;
      end else begin
         r_l2Resp <= w_respNext;
         if (w_readHitResp) begin
            r_l2Rdata <= r_lineData[w_readIdx];
         end else if (w_readDone) begin
            r_l2Rdata <= wbBus.pmem_rdata;
         end
      end
   end

   // The write data is read straight out of the head entry; that entry is
   // frozen while it is in flight, so it stays stable for memory.
   assign wbBus.l2_resp      = r_l2Resp;
   assign wbBus.l2_rdata     = r_l2Rdata;
   assign wbBus.pmem_read    = r_pmemRead;
   assign wbBus.pmem_write   = r_pmemWrite;
   assign wbBus.pmem_address = r_pmemAddr;
   assign wbBus.pmem_wdata   = r_pmemWrite ? r_lineData[r_head] : '0;
   assign wbBus.wb_empty     = (r_count == '0) && (r_state != DRAIN);

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// ---------------------------------------------------------------------------
// tb_l2_writeback_buffer
//   Directed testbench for l2_writeback_buffer (DEPTH = 2). The bench plays
//   both the L2 controller and physical memory, cycle by cycle, and compares
//   latencies, addresses and data against hand-computed values.
// ---------------------------------------------------------------------------
module tb_l2_writeback_buffer;

   logic clk;
   logic reset;

   l2_writeback_buffer_if wbBus();

   l2_writeback_buffer #(.DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .wbBus (wbBus)
   );

   localparam logic [127:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
   localparam logic [127:0] D1 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
   localparam logic [127:0] DA = 128'hA0A0_A0A0_0000_0000_0000_0000_0000_00A1;
   localparam logic [127:0] DB = 128'hB0B0_B0B0_0000_0000_0000_0000_0000_00B1;
   localparam logic [127:0] DC = 128'hC0C0_C0C0_0000_0000_0000_0000_0000_00C1;
   localparam logic [127:0] DR = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
   localparam logic [127:0] DM = 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788;
   localparam logic [127:0] E0 = 128'hE0E0_0000_0000_0000_0000_0000_0000_0001;
   localparam logic [127:0] E1 = 128'hE1E1_0000_0000_0000_0000_0000_0000_0002;
   localparam logic [127:0] E2 = 128'hE2E2_0000_0000_0000_0000_0000_0000_0003;

   int   vectorCount = 0;
   int   missCount   = 0;
   logic pmemReadSeen;

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Remember whether the buffer ever asked memory for a read; several
   // scenarios require that it never does.
   always @(negedge clk) begin
      if (wbBus.pmem_read === 1'b1) begin
         pmemReadSeen = 1'b1;
      end
   end

   // Safety net so a wedged run still ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [127:0] wdata);
      wbBus.l2_read    = rd;
      wbBus.l2_write   = wr;
      wbBus.l2_address = addr;
      wbBus.l2_wdata   = wdata;
   endtask

   // One complete L2 transaction with memory held quiet: raise the request,
   // count cycles to l2_resp (bounded), check latency and optionally data,
   // then drop the request and let the response cycle pass.
   task automatic l2Transfer(input string tag, input logic isWrite, input logic [15:0] addr,
                             input logic [127:0] wdata, input int expLatency,
                             input logic checkData, input logic [127:0] expRdata);
      int cycles;
      cycles = 0;
      applyStimulus(!isWrite, isWrite, addr, wdata);
      do begin
         tick();
         cycles++;
      end while ((wbBus.l2_resp !== 1'b1) && (cycles < 20));
      checkOutput({tag, "_lat"}, 128'(cycles), 128'(expLatency));
      if (checkData) begin
         checkOutput({tag, "_rdata"}, wbBus.l2_rdata, expRdata);
      end
      applyStimulus(1'b0, 1'b0, 16'h0000, '0);
      tick();
   endtask

   // Wait (bounded) for a drain, check its address and data, then complete it.
   task automatic drainExpect(input string tag, input logic [15:0] addr, input logic [127:0] data);
      int cycles;
      cycles = 0;
      while ((wbBus.pmem_write !== 1'b1) && (cycles < 10)) begin
         tick();
         cycles++;
      end
      checkOutput({tag, "_wr"}, 128'(wbBus.pmem_write), 128'(1));
      checkOutput({tag, "_rd"}, 128'(wbBus.pmem_read), 128'(0));
      checkOutput({tag, "_addr"}, 128'(wbBus.pmem_address), 128'(addr));
      checkOutput({tag, "_wdata"}, wbBus.pmem_wdata, data);
      wbBus.pmem_resp = 1'b1;
      tick();
      wbBus.pmem_resp = 1'b0;
   endtask

   initial begin
      logic sawResp;

      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0000, '0);
      wbBus.pmem_rdata = '0;
      wbBus.pmem_resp  = 1'b0;
      pmemReadSeen     = 1'b0;
      tick();
      tick();

      // Reset values
      checkOutput("rst_resp",  128'(wbBus.l2_resp),    128'(0));
      checkOutput("rst_rdata", wbBus.l2_rdata,          '0);
      checkOutput("rst_pread", 128'(wbBus.pmem_read),  128'(0));
      checkOutput("rst_pwrite",128'(wbBus.pmem_write), 128'(0));
      checkOutput("rst_paddr", 128'(wbBus.pmem_address), 128'(0));
      checkOutput("rst_empty", 128'(wbBus.wb_empty),   128'(1));
      #2 reset = 1'b0;
      tick();

      $display("[TB] scenario 1: single write-back and drain");
      pmemReadSeen = 1'b0;
      l2Transfer("t1_wr", 1'b1, 16'h1230, D0, 1, 1'b0, '0);
      checkOutput("t1_notEmpty", 128'(wbBus.wb_empty), 128'(0));
      drainExpect("t1_drain", 16'h1230, D0);
      checkOutput("t1_empty", 128'(wbBus.wb_empty), 128'(1));
      checkOutput("t1_noPread", 128'(pmemReadSeen), 128'(0));

      $display("[TB] scenario 2: read forwarded from buffer");
      pmemReadSeen = 1'b0;
      l2Transfer("t2_wr", 1'b1, 16'h1230, D0, 1, 1'b0, '0);
      l2Transfer("t2_rd", 1'b0, 16'h1238, '0, 1, 1'b1, D0);
      checkOutput("t2_noPread", 128'(pmemReadSeen), 128'(0));
      drainExpect("t2_drain", 16'h1230, D0);

      $display("[TB] scenario 3: full buffer stalls the third write");
      l2Transfer("t3_wrA", 1'b1, 16'h1000, DA, 1, 1'b0, '0);
      l2Transfer("t3_wrB", 1'b1, 16'h2000, DB, 1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 16'h3000, DC);
      sawResp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (wbBus.l2_resp === 1'b1) sawResp = 1'b1;
      end
      checkOutput("t3_stall", 128'(sawResp), 128'(0));
      checkOutput("t3_headAddr", 128'(wbBus.pmem_address), 128'(16'h1000));
      checkOutput("t3_headData", wbBus.pmem_wdata, DA);
      wbBus.pmem_resp = 1'b1;
      tick();
      wbBus.pmem_resp = 1'b0;
      checkOutput("t3_noBypass", 128'(wbBus.l2_resp), 128'(0));
      tick();
      checkOutput("t3_respC", 128'(wbBus.l2_resp), 128'(1));
      applyStimulus(1'b0, 1'b0, 16'h0000, '0);
      tick();
      drainExpect("t3_drainB", 16'h2000, DB);
      drainExpect("t3_drainC", 16'h3000, DC);
      checkOutput("t3_empty", 128'(wbBus.wb_empty), 128'(1));

      $display("[TB] scenario 4: read miss takes priority over draining");
      l2Transfer("t4_wrA", 1'b1, 16'h1230, D1, 1, 1'b0, '0);
      l2Transfer("t4_wrB", 1'b1, 16'h5670, DB, 1, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 16'h4000, '0);
      tick();
      tick();
      checkOutput("t4_waitResp", 128'(wbBus.l2_resp), 128'(0));
      checkOutput("t4_waitPread", 128'(wbBus.pmem_read), 128'(0));
      drainExpect("t4_drainA", 16'h1230, D1);
      tick();
      checkOutput("t4_pread", 128'(wbBus.pmem_read), 128'(1));
      checkOutput("t4_pwrite", 128'(wbBus.pmem_write), 128'(0));
      checkOutput("t4_paddr", 128'(wbBus.pmem_address), 128'(16'h4000));
      wbBus.pmem_rdata = DR;
      wbBus.pmem_resp  = 1'b1;
      tick();
      wbBus.pmem_resp  = 1'b0;
      checkOutput("t4_resp", 128'(wbBus.l2_resp), 128'(1));
      checkOutput("t4_rdata", wbBus.l2_rdata, DR);
      applyStimulus(1'b0, 1'b0, 16'h0000, '0);
      tick();
      drainExpect("t4_drainB", 16'h5670, DB);

      $display("[TB] scenario 5: same-line write while head is in flight");
      pmemReadSeen = 1'b0;
      l2Transfer("t5_wr0", 1'b1, 16'h7770, D0, 1, 1'b0, '0);
      l2Transfer("t5_wr1", 1'b1, 16'h7770, D1, 1, 1'b0, '0);
      checkOutput("t5_inflight", wbBus.pmem_wdata, D0);
      l2Transfer("t5_rd", 1'b0, 16'h7774, '0, 1, 1'b1, D1);
      checkOutput("t5_inflight2", wbBus.pmem_wdata, D0);
      drainExpect("t5_drain0", 16'h7770, D0);
      drainExpect("t5_drain1", 16'h7770, D1);
      checkOutput("t5_noPread", 128'(pmemReadSeen), 128'(0));

      $display("[TB] scenario 7: overwrite in place while full");
      l2Transfer("t7_wrE0", 1'b1, 16'h9990, E0, 1, 1'b0, '0);
      l2Transfer("t7_wrE1", 1'b1, 16'hAAA0, E1, 1, 1'b0, '0);
      l2Transfer("t7_wrE2", 1'b1, 16'hAAA0, E2, 1, 1'b0, '0);
      drainExpect("t7_drainE0", 16'h9990, E0);
      drainExpect("t7_drainE2", 16'hAAA0, E2);
      tick();
      checkOutput("t7_empty", 128'(wbBus.wb_empty), 128'(1));
      checkOutput("t7_idle", 128'(wbBus.pmem_write), 128'(0));

      $display("[TB] scenario 6: reset during a drain");
      l2Transfer("t6_wr", 1'b1, 16'h1230, D0, 1, 1'b0, '0);
      checkOutput("t6_draining", 128'(wbBus.pmem_write), 128'(1));
      #2 reset = 1'b1;
      #1;
      checkOutput("t6_pwriteDrop", 128'(wbBus.pmem_write), 128'(0));
      checkOutput("t6_emptyNow", 128'(wbBus.wb_empty), 128'(1));
      #2 reset = 1'b0;
      tick();
      applyStimulus(1'b1, 1'b0, 16'h1230, '0);
      tick();
      checkOutput("t6_pread", 128'(wbBus.pmem_read), 128'(1));
      checkOutput("t6_paddr", 128'(wbBus.pmem_address), 128'(16'h1230));
      wbBus.pmem_rdata = DM;
      wbBus.pmem_resp  = 1'b1;
      tick();
      wbBus.pmem_resp  = 1'b0;
      checkOutput("t6_resp", 128'(wbBus.l2_resp), 128'(1));
      checkOutput("t6_rdata", wbBus.l2_rdata, DM);
      applyStimulus(1'b0, 1'b0, 16'h0000, '0);
      tick();
      checkOutput("t6_preadDone", 128'(wbBus.pmem_read), 128'(0));

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
